qpu_dtcm_icb_arbiter: RTL and testbench
=======================================

// Module: qpu_dtcm_icb_arbiter
// PURPOSE
//  Two-requester ICB arbiter in front of the DTCM SRAM controller. Port 0 = LSU, port 1 = measurement-result writer.
//  Round-robin grant; at most one transaction outstanding, matching the single-transaction DTCM ICB.
//  Routes the response back to the owning port and drives an activity flag for DTCM clock gating.
// PARAMETERS
//  AW  16  ICB address width (= QPU_DTCM_ADDR_WIDTH)
//  DW  32  ICB data width
//  MW  4   write-mask width (DW/8)
// PORTS
//  clk                       in   1   core clock
//  rst                       in   1   synchronous reset, active-high
//  p{0,1}_icb_cmd_valid      in   1   requester cmd valid
//  p{0,1}_icb_cmd_ready      out  1   requester cmd ready
//  p{0,1}_icb_cmd_addr       in   AW  cmd address
//  p{0,1}_icb_cmd_read       in   1   1 = read, 0 = write
//  p{0,1}_icb_cmd_wdata      in   DW  write data
//  p{0,1}_icb_cmd_wmask      in   MW  byte write mask
//  p{0,1}_icb_rsp_valid      out  1   response valid, owner port only
//  p{0,1}_icb_rsp_ready      in   1   response ready
//  p{0,1}_icb_rsp_rdata      out  DW  read data, broadcast to both ports
//  o_icb_cmd_valid/ready     out/in 1 cmd handshake to DTCM ctrl
//  o_icb_cmd_addr/read/wdata/wmask  out AW/1/DW/MW  muxed cmd fields
//  o_icb_rsp_valid/ready     in/out 1 rsp handshake from DTCM ctrl
//  o_icb_rsp_rdata           in   DW  read data
//  arb_active                out  1   p0/p1 cmd_valid | state != IDLE
//  arb_err                   out  1   sticky: o_icb_rsp_valid seen while IDLE
// BEHAVIOUR
//  Reset: state = IDLE, last_gnt = 1 (port 0 wins first tie), lock = 0, arb_err = 0.
//   All valid/ready outputs are 0 during and after reset until inputs request.
//  States:
//   IDLE: no transaction outstanding.
//   WAIT_RSP: one cmd accepted downstream; owner register holds its port.
//  IDLE arbitration:
//   one valid -> that port wins.
//   both valid -> the port != last_gnt wins.
//   Selection is combinational when lock = 0.
//  Stability: if o_icb_cmd_valid & !o_icb_cmd_ready, set lock and hold the selected port.
//   Later requests from the other port do not preempt it. Clear lock on handshake.
//  Cmd path in IDLE:
//   o_icb_cmd_valid = sel port's valid; fields muxed from sel port.
//   sel port's cmd_ready = o_icb_cmd_ready; other port's cmd_ready = 0.
//  IDLE -> WAIT_RSP on o_icb_cmd_valid & o_icb_cmd_ready: owner <= sel, last_gnt <= sel.
//  WAIT_RSP:
//   o_icb_cmd_valid = 0; both cmd_ready = 0.
//   owner's rsp_valid = o_icb_rsp_valid; o_icb_rsp_ready = owner's rsp_ready; other rsp_valid = 0.
//   WAIT_RSP -> IDLE on the rsp handshake.
//  No same-cycle rsp-to-cmd overlap; the next cmd can issue the cycle after rsp handshake.
//   Minimum 2 cycles per transaction with the 1-cycle DTCM ctrl.
//  Downstream backpressure: owner rsp_ready = 0 holds WAIT_RSP indefinitely; cmd ports stay blocked.
//  arb_err: set when o_icb_rsp_valid = 1 in IDLE. That response is ignored, with o_icb_rsp_ready = 1 to drain it.
//   Cleared only by rst.
//  Reset mid-transaction: owner/lock discarded, return to IDLE. DTCM ctrl shares rst; no response replay.
//  Pure mux/state logic: no data buffering, no width conversion, no address decode.
// TESTING
//  T1: p0 read 0x0010, ctrl ready=1, rsp rdata=0xDEADBEEF next cycle -> p0_rsp_valid=1, rdata=0xDEADBEEF; p1_rsp_valid=0.
//  T2: p0 and p1 valid same cycle from reset -> p0 granted first, then p1.
//   Both held valid -> grants alternate 0,1,0,1 over 4 txns.
//  T3: p1 write 0x0020 wdata 0x12345678 wmask 0xF, o_cmd_ready=0 for 3 cycles, p0 raises valid on cycle 2
//   -> o_cmd fields stay p1's, p1 wins the handshake, p0 served next.
//  T4: p0 rsp_ready=0 for 5 cycles -> o_rsp_ready=0, p1 cmd_ready=0 throughout; p1 granted the cycle after p0 rsp handshake.
//  T5: o_icb_rsp_valid pulsed in IDLE -> arb_err=1 and stays 1; no port rsp_valid; rst clears it.
//  T6: rst asserted in WAIT_RSP -> next cycle IDLE, all valids 0, arb_active follows inputs only.

Source files
------------

// File: rtl/qpu_dtcm_icb_arbiter_if.sv
// rtl/qpu_dtcm_icb_arbiter_if.sv - ICB command/response link between one master and one slave
interface qpu_dtcm_icb_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 32,
    parameter int MW = 4
);
    logic          icb_cmd_valid;
    logic          icb_cmd_ready;
    logic [AW-1:0] icb_cmd_addr;
    logic          icb_cmd_read;
    logic [DW-1:0] icb_cmd_wdata;
    logic [MW-1:0] icb_cmd_wmask;
    logic          icb_rsp_valid;
    logic          icb_rsp_ready;
    logic [DW-1:0] icb_rsp_rdata;

    modport master (
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata
    );
endinterface

// File: rtl/qpu_dtcm_icb_arbiter.sv
// rtl/qpu_dtcm_icb_arbiter.sv - two-port round-robin ICB arbiter in front of the DTCM controller
module qpu_dtcm_icb_arbiter #(
    parameter int AW = 16,
    parameter int DW = 32,
    parameter int MW = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    qpu_dtcm_icb_arbiter_if.slave          p0_icb,
    qpu_dtcm_icb_arbiter_if.slave          p1_icb,
    qpu_dtcm_icb_arbiter_if.master         o_icb,
    output logic                           arb_active,
    output logic                           arb_err
);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_RSP = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_last_gnt;
    logic          r_lock;
    logic          r_lock_sel;
    logic          r_owner;
    logic          r_err;

    logic          w_sel;
    logic          w_sel_valid;
    logic          w_owner_rsp_ready;
    logic          w_cmd_hs;
    logic          w_rsp_hs;
    logic [AW-1:0] w_cmd_addr;
    logic          w_cmd_read;
    logic [DW-1:0] w_cmd_wdata;
    logic [MW-1:0] w_cmd_wmask;

    // Port selection: a stalled command keeps its port, otherwise a lone requester wins and ties go away from the last grant
    always_comb begin
        w_sel = ~r_last_gnt;
        if (r_lock) begin
            w_sel = r_lock_sel;
        end else if (p0_icb.icb_cmd_valid ^ p1_icb.icb_cmd_valid) begin
            w_sel = p1_icb.icb_cmd_valid;
        end
    end

    assign w_sel_valid       = w_sel ? p1_icb.icb_cmd_valid : p0_icb.icb_cmd_valid;
    assign w_cmd_addr        = w_sel ? p1_icb.icb_cmd_addr  : p0_icb.icb_cmd_addr;
    assign w_cmd_read        = w_sel ? p1_icb.icb_cmd_read  : p0_icb.icb_cmd_read;
    assign w_cmd_wdata       = w_sel ? p1_icb.icb_cmd_wdata : p0_icb.icb_cmd_wdata;
    assign w_cmd_wmask       = w_sel ? p1_icb.icb_cmd_wmask : p0_icb.icb_cmd_wmask;
    assign w_owner_rsp_ready = r_owner ? p1_icb.icb_rsp_ready : p0_icb.icb_rsp_ready;

    assign w_cmd_hs = (r_state == ST_IDLE) & w_sel_valid & o_icb.icb_cmd_ready;
    assign w_rsp_hs = (r_state == ST_WAIT_RSP) & o_icb.icb_rsp_valid & w_owner_rsp_ready;

    assign o_icb.icb_cmd_addr  = w_cmd_addr;
    assign o_icb.icb_cmd_read  = w_cmd_read;
    assign o_icb.icb_cmd_wdata = w_cmd_wdata;
    assign o_icb.icb_cmd_wmask = w_cmd_wmask;

    // Read data is not steered; only rsp_valid tells a port the data is its own
    assign p0_icb.icb_rsp_rdata = o_icb.icb_rsp_rdata;
    assign p1_icb.icb_rsp_rdata = o_icb.icb_rsp_rdata;

    assign arb_active = p0_icb.icb_cmd_valid | p1_icb.icb_cmd_valid | (r_state != ST_IDLE);
    assign arb_err    = r_err;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake routing; every valid/ready output is held low while reset is asserted
    always_comb begin
        w_state_nxt          = r_state;
        o_icb.icb_cmd_valid  = 1'b0;
        o_icb.icb_rsp_ready  = 1'b0;
        p0_icb.icb_cmd_ready = 1'b0;
        p1_icb.icb_cmd_ready = 1'b0;
        p0_icb.icb_rsp_valid = 1'b0;
        p1_icb.icb_rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_icb.icb_cmd_valid  = w_sel_valid;
                p0_icb.icb_cmd_ready = ~w_sel & p0_icb.icb_cmd_valid & o_icb.icb_cmd_ready;
                p1_icb.icb_cmd_ready =  w_sel & p1_icb.icb_cmd_valid & o_icb.icb_cmd_ready;
                // A response with nothing outstanding is drained and dropped
                o_icb.icb_rsp_ready  = o_icb.icb_rsp_valid;
                if (w_cmd_hs) begin
                    w_state_nxt = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                p0_icb.icb_rsp_valid = ~r_owner & o_icb.icb_rsp_valid;
                p1_icb.icb_rsp_valid =  r_owner & o_icb.icb_rsp_valid;
                o_icb.icb_rsp_ready  = w_owner_rsp_ready;
                if (w_rsp_hs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (rst) begin
            o_icb.icb_cmd_valid  = 1'b0;
            o_icb.icb_rsp_ready  = 1'b0;
            p0_icb.icb_cmd_ready = 1'b0;
            p1_icb.icb_cmd_ready = 1'b0;
            p0_icb.icb_rsp_valid = 1'b0;
            p1_icb.icb_rsp_valid = 1'b0;
        end
    end

    // Grant bookkeeping: owner and round-robin pointer on accept, stall lock, sticky stray-response flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner    <= 1'b0;
            r_last_gnt <= 1'b1;
            r_lock     <= 1'b0;
            r_lock_sel <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_cmd_hs) begin
                r_owner    <= w_sel;
                r_last_gnt <= w_sel;
                r_lock     <= 1'b0;
            end else if ((r_state == ST_IDLE) && w_sel_valid) begin
                r_lock     <= 1'b1;
                r_lock_sel <= w_sel;
            end else begin
                r_lock     <= 1'b0;
            end
            if ((r_state == ST_IDLE) && o_icb.icb_rsp_valid) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qpu_dtcm_icb_arbiter.sv
// tb/tb_qpu_dtcm_icb_arbiter.sv - directed scoreboard bench for the DTCM ICB arbiter
module tb_qpu_dtcm_icb_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MW = 4;

    logic clk = 1'b0;
    logic rst;
    logic arb_active;
    logic arb_err;

    qpu_dtcm_icb_arbiter_if #(.AW(AW), .DW(DW), .MW(MW)) p0_if ();
    qpu_dtcm_icb_arbiter_if #(.AW(AW), .DW(DW), .MW(MW)) p1_if ();
    qpu_dtcm_icb_arbiter_if #(.AW(AW), .DW(DW), .MW(MW)) dn_if ();

    qpu_dtcm_icb_arbiter #(.AW(AW), .DW(DW), .MW(MW)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .p0_icb     (p0_if),
        .p1_icb     (p1_if),
        .o_icb      (dn_if),
        .arb_active (arb_active),
        .arb_err    (arb_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] rq_addr [2];
    logic          rq_read [2];
    logic [DW-1:0] rq_wdata[2];
    logic [MW-1:0] rq_wmask[2];
    int            rq_cnt  [2];
    logic          rq_rsp_ready[2];

    logic          dn_cmd_ready_q;
    logic          dn_rsp_valid_q;
    logic [DW-1:0] dn_rdata_q;

    logic [54:0]   exp_cmd[$];
    logic [33:0]   exp_rsp[$];

    logic          s_dn_cmd_valid, s_dn_rsp_ready, s_p0_cmd_ready, s_p1_cmd_ready;
    logic          s_p0_rsp_valid, s_p1_rsp_valid, s_active, s_err;
    logic [AW-1:0] s_addr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return (a == 16'h0010) ? 32'hDEADBEEF : {a ^ 16'h5A5A, a};
    endfunction

    task automatic expect_txn(input int p, input logic [AW-1:0] a, input logic rd,
                              input logic [DW-1:0] wd, input logic [MW-1:0] wm, input bit with_rsp);
        exp_cmd.push_back({(p == 1) ? 2'b10 : 2'b01, a, rd, wd, wm});
        if (with_rsp) exp_rsp.push_back({p == 0, p == 1, mem_val(a)});
    endtask

    task automatic drive();
        p0_if.icb_cmd_valid = (rq_cnt[0] > 0);
        p0_if.icb_cmd_addr  = rq_addr[0];
        p0_if.icb_cmd_read  = rq_read[0];
        p0_if.icb_cmd_wdata = rq_wdata[0];
        p0_if.icb_cmd_wmask = rq_wmask[0];
        p0_if.icb_rsp_ready = rq_rsp_ready[0];
        p1_if.icb_cmd_valid = (rq_cnt[1] > 0);
        p1_if.icb_cmd_addr  = rq_addr[1];
        p1_if.icb_cmd_read  = rq_read[1];
        p1_if.icb_cmd_wdata = rq_wdata[1];
        p1_if.icb_cmd_wmask = rq_wmask[1];
        p1_if.icb_rsp_ready = rq_rsp_ready[1];
        dn_if.icb_cmd_ready = dn_cmd_ready_q;
        dn_if.icb_rsp_valid = dn_rsp_valid_q;
        dn_if.icb_rsp_rdata = dn_rdata_q;
    endtask

    task automatic issue(input int p, input logic [AW-1:0] a, input logic rd,
                         input logic [DW-1:0] wd, input logic [MW-1:0] wm, input int n);
        rq_addr[p] = a; rq_read[p] = rd; rq_wdata[p] = wd; rq_wmask[p] = wm; rq_cnt[p] = n;
        drive();
    endtask

    // One clock: observe at the falling edge, then update requesters and the 1-cycle DTCM model
    task automatic step();
        logic cmd_hs, rsp_hs, p0_hs, p1_hs, prsp_hs;
        logic [AW-1:0] hs_addr;
        logic [54:0] ec;
        logic [33:0] er;
        @(negedge clk);
        s_dn_cmd_valid = dn_if.icb_cmd_valid;  s_dn_rsp_ready = dn_if.icb_rsp_ready;
        s_p0_cmd_ready = p0_if.icb_cmd_ready;  s_p1_cmd_ready = p1_if.icb_cmd_ready;
        s_p0_rsp_valid = p0_if.icb_rsp_valid;  s_p1_rsp_valid = p1_if.icb_rsp_valid;
        s_active = arb_active; s_err = arb_err; s_addr = dn_if.icb_cmd_addr;
        cmd_hs  = dn_if.icb_cmd_valid & dn_if.icb_cmd_ready;
        rsp_hs  = dn_if.icb_rsp_valid & dn_if.icb_rsp_ready;
        p0_hs   = p0_if.icb_cmd_valid & p0_if.icb_cmd_ready;
        p1_hs   = p1_if.icb_cmd_valid & p1_if.icb_cmd_ready;
        prsp_hs = (p0_if.icb_rsp_valid & p0_if.icb_rsp_ready) | (p1_if.icb_rsp_valid & p1_if.icb_rsp_ready);
        hs_addr = dn_if.icb_cmd_addr;
        if (cmd_hs) begin
            check("cmd_expected", exp_cmd.size() > 0, 1);
            if (exp_cmd.size() > 0) begin
                ec = exp_cmd.pop_front();
                check("cmd", {p1_if.icb_cmd_ready, p0_if.icb_cmd_ready, dn_if.icb_cmd_addr,
                              dn_if.icb_cmd_read, dn_if.icb_cmd_wdata, dn_if.icb_cmd_wmask}, ec);
            end
        end
        if (prsp_hs) begin
            check("rsp_expected", exp_rsp.size() > 0, 1);
            if (exp_rsp.size() > 0) begin
                er = exp_rsp.pop_front();
                // rdata is taken from the non-owner port so the broadcast is exercised too
                check("rsp", {p0_if.icb_rsp_valid, p1_if.icb_rsp_valid,
                              p0_if.icb_rsp_valid ? p1_if.icb_rsp_rdata : p0_if.icb_rsp_rdata}, er);
            end
        end
        @(posedge clk);
        #1;
        if (p0_hs && rq_cnt[0] > 0) begin rq_cnt[0]--; rq_addr[0] += 16'd4; end
        if (p1_hs && rq_cnt[1] > 0) begin rq_cnt[1]--; rq_addr[1] += 16'd4; end
        if (rsp_hs) dn_rsp_valid_q = 1'b0;
        if (cmd_hs) begin dn_rsp_valid_q = 1'b1; dn_rdata_q = mem_val(hs_addr); end
        drive();
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int n = 0;
        while ((exp_cmd.size() != 0 || exp_rsp.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_drained"}, exp_cmd.size() + exp_rsp.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; rq_cnt[0] = 0; rq_cnt[1] = 0; dn_rsp_valid_q = 1'b0;
        drive();
        step();
        rst = 1'b0;
        drive();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rq_addr[i] = '0; rq_read[i] = 1'b1; rq_wdata[i] = '0; rq_wmask[i] = '0;
            rq_cnt[i] = 0; rq_rsp_ready[i] = 1'b1;
        end
        dn_cmd_ready_q = 1'b1; dn_rsp_valid_q = 1'b0; dn_rdata_q = '0;
        rq_cnt[0] = 1;
        drive();

        // Reset: handshake outputs held low even with a request and a ready controller
        step();
        step();
        check("reset_outputs", {s_dn_cmd_valid, s_dn_rsp_ready, s_p0_cmd_ready, s_p1_cmd_ready,
                                s_p0_rsp_valid, s_p1_rsp_valid, s_err}, 7'b0);
        rq_cnt[0] = 0;
        rst = 1'b0;
        drive();
        step();
        check("post_reset_idle", {s_dn_cmd_valid, s_p0_cmd_ready, s_p1_cmd_ready, s_active, s_err}, 5'b0);

        // T1: single p0 read, response the cycle after the accept
        issue(0, 16'h0010, 1'b1, 32'h0, 4'h0, 1);
        expect_txn(0, 16'h0010, 1'b1, 32'h0, 4'h0, 1);
        step();
        check("t1_cmd_accepted", exp_cmd.size(), 0);
        step();
        check("t1_rsp_next_cycle", exp_rsp.size(), 0);
        check("t1_active_wait", s_active, 1'b1);
        step();

        // T2: both request from reset, held for two each; grants alternate 0,1,0,1
        do_reset();
        issue(0, 16'h0100, 1'b1, 32'h0, 4'h0, 2);
        issue(1, 16'h0200, 1'b1, 32'h0, 4'h0, 2);
        expect_txn(0, 16'h0100, 1'b1, 32'h0, 4'h0, 1);
        expect_txn(1, 16'h0200, 1'b1, 32'h0, 4'h0, 1);
        expect_txn(0, 16'h0104, 1'b1, 32'h0, 4'h0, 1);
        expect_txn(1, 16'h0204, 1'b1, 32'h0, 4'h0, 1);
        run_until_done("t2", 40);

        // T3: stalled p1 write keeps the bus although p0 would win a fresh tie
        dn_cmd_ready_q = 1'b0;
        issue(1, 16'h0020, 1'b0, 32'h12345678, 4'hF, 1);
        expect_txn(1, 16'h0020, 1'b0, 32'h12345678, 4'hF, 1);
        expect_txn(0, 16'h0030, 1'b1, 32'h0, 4'h0, 1);
        step();
        check("t3_cycle1", {s_dn_cmd_valid, s_addr}, {1'b1, 16'h0020});
        issue(0, 16'h0030, 1'b1, 32'h0, 4'h0, 1);
        step();
        check("t3_cycle2", {s_dn_cmd_valid, s_addr, s_p0_cmd_ready}, {1'b1, 16'h0020, 1'b0});
        step();
        check("t3_cycle3", {s_dn_cmd_valid, s_addr, s_p0_cmd_ready}, {1'b1, 16'h0020, 1'b0});
        dn_cmd_ready_q = 1'b1;
        drive();
        run_until_done("t3", 40);

        // T4: owner holds off its response; the other port stays blocked until the cycle after
        rq_rsp_ready[0] = 1'b0;
        issue(0, 16'h0040, 1'b1, 32'h0, 4'h0, 1);
        expect_txn(0, 16'h0040, 1'b1, 32'h0, 4'h0, 1);
        expect_txn(1, 16'h0050, 1'b1, 32'h0, 4'h0, 1);
        step();
        issue(1, 16'h0050, 1'b1, 32'h0, 4'h0, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_backpressure", {s_dn_rsp_ready, s_p1_cmd_ready, s_p0_rsp_valid}, 3'b001);
        end
        rq_rsp_ready[0] = 1'b1;
        drive();
        step();
        step();
        check("t4_p1_next_cycle", {s_p1_cmd_ready, s_dn_cmd_valid, s_addr}, {1'b1, 1'b1, 16'h0050});
        run_until_done("t4", 20);

        // T5: stray response in IDLE is drained, flagged, and the flag is sticky until reset
        dn_rsp_valid_q = 1'b1;
        dn_rdata_q = 32'hBAD0BAD0;
        drive();
        step();
        check("t5_drain", {s_dn_rsp_ready, s_p0_rsp_valid, s_p1_rsp_valid, s_err}, 4'b1000);
        step();
        check("t5_err_set", s_err, 1'b1);
        step();
        step();
        check("t5_err_sticky", {s_err, s_p0_rsp_valid, s_p1_rsp_valid}, 3'b100);
        do_reset();
        step();
        check("t5_err_cleared", s_err, 1'b0);

        // T6: reset while waiting on a response abandons it
        rq_rsp_ready[0] = 1'b0;
        issue(0, 16'h0060, 1'b1, 32'h0, 4'h0, 1);
        expect_txn(0, 16'h0060, 1'b1, 32'h0, 4'h0, 0);
        step();
        step();
        check("t6_waiting", {s_p0_rsp_valid, s_active}, 2'b11);
        rst = 1'b1;
        rq_cnt[0] = 0;
        drive();
        step();
        check("t6_in_reset", {s_dn_cmd_valid, s_dn_rsp_ready, s_p0_rsp_valid, s_p1_rsp_valid}, 4'b0);
        rst = 1'b0;
        dn_rsp_valid_q = 1'b0;
        rq_rsp_ready[0] = 1'b1;
        drive();
        step();
        check("t6_idle_after", {s_dn_cmd_valid, s_dn_rsp_ready, s_p0_rsp_valid, s_p1_rsp_valid, s_active}, 5'b0);
        issue(1, 16'h0070, 1'b1, 32'h0, 4'h0, 1);
        expect_txn(1, 16'h0070, 1'b1, 32'h0, 4'h0, 1);
        step();
        check("t6_active_follows", {s_active, s_p1_cmd_ready}, 2'b11);
        run_until_done("t6", 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
